// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------------+
// | fetch_pkg : shared types, constants and width helpers for the fetch stage |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Counter width able to hold the value 'depth' itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +--------------------------------------------------------------------------+
// | fetch_fifo : synchronous FIFO with async reset, clear and occupancy count |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic                        clear,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is allowed when the head leaves the same cycle.
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | fetch_unit : credit-based instruction fetch with PC tagging and flush     |
// |              discard; FETCH_STATS_EN adds stall/flush counters.           |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter int BUF_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_misaligned
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  localparam int OW = cnt_width(MAX_OUTSTANDING);
  localparam int BW = cnt_width(BUF_DEPTH);

  fetch_state_e    r_state, w_state_next;
  logic [OW-1:0]   w_outstanding, r_discard, w_discard_next;
  logic [BW-1:0]   w_buf_count;
  logic            r_misaligned, w_misaligned_next;
  logic            w_tag_full, w_tag_empty, w_buf_full, w_buf_empty;
  logic [XLEN-1:0] w_tag;
  logic [2*XLEN-1:0] w_head, r_last_head;
  logic            w_credit_ok, w_accept, w_rsp_fire, w_buf_push, w_buf_pop;

  // Reserve buffer space for every in-flight request so responses never stall.
  assign w_credit_ok = ((32'(w_outstanding) + 32'(w_buf_count)) < 32'(BUF_DEPTH)) && !w_tag_full;

  assign imem_req_valid = !reset && (r_state == RUN) && !flush && w_credit_ok &&
                          !r_misaligned && (pc_in[1:0] == 2'b00);
  assign imem_req_addr  = reset ? '0 : pc_in;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign pc_advance     = w_accept;

  assign w_rsp_fire = imem_rsp_valid && !w_tag_empty;
  assign w_buf_push = w_rsp_fire && (r_discard == '0) && !flush;
  assign w_buf_pop  = instr_valid && instr_ready && !flush;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (pc_in),
    .pop       (w_rsp_fire),
    .clear     (1'b0),
    .pop_data  (w_tag),
    .full      (w_tag_full),
    .empty     (w_tag_empty),
    .count     (w_outstanding)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (w_buf_push),
    .push_data ({w_tag, imem_rsp_data}),
    .pop       (w_buf_pop),
    .clear     (flush),
    .pop_data  (w_head),
    .full      (w_buf_full),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  always_comb begin
    w_state_next      = r_state;
    w_discard_next    = r_discard;
    w_misaligned_next = r_misaligned;
    if (flush) begin
      // A response arriving with the flush is already one of the discarded ones.
      w_discard_next    = w_outstanding - OW'(w_rsp_fire);
      w_misaligned_next = 1'b0;
      w_state_next      = (w_discard_next != '0) ? DRAIN : RUN;
    end else begin
      if (w_rsp_fire && (r_discard != '0)) begin
        w_discard_next = r_discard - 1'b1;
        if (r_discard == OW'(1)) w_state_next = RUN;
      end
      if ((r_state == RUN) && (pc_in[1:0] != 2'b00) && w_credit_ok)
        w_misaligned_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_discard    <= '0;
      r_misaligned <= 1'b0;
      r_last_head  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_discard    <= w_discard_next;
      r_misaligned <= w_misaligned_next;
      if (!w_buf_empty) r_last_head <= w_head;
    end
  end

  assign instr_valid             = !w_buf_empty;
  assign {instr_pc, instr_data}  = w_buf_empty ? r_last_head : w_head;
  assign fetch_misaligned        = r_misaligned;

`ifdef FETCH_STATS_EN
  logic w_stall;
  assign w_stall = ((r_state == RUN) && !imem_req_valid) || (imem_req_valid && !imem_req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (w_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && (flush_count != '1))    flush_count  <= flush_count + 1'b1;
    end
  end
`endif

  a_rsp_without_req : assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && w_tag_empty))
    else $warning("fetch_unit: imem response with no outstanding request ignored");

  a_buf_overflow : assert property (@(posedge clk) disable iff (reset)
    !(w_buf_push && w_buf_full && !w_buf_pop))
    else $error("fetch_unit: instruction buffer overflow");

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed stimulus with a queue scoreboard for fetch_unit  |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = 32'h40;
  logic        pc_advance;
  logic        flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  fetch_unit #(.XLEN(32), .BUF_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_in            (pc_in),
    .pc_advance       (pc_advance),
    .flush            (flush),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
`ifdef FETCH_STATS_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic        rsp_hold = 1'b0;

  // Instruction memory contents: data word is the address xor a fixed pattern.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1234_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  // One cycle of PC register + 1-cycle-latency memory behaviour.
  task automatic tick();
    logic acc, adv;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    adv = pc_advance;
    if (acc) begin
      pend.push_back(imem_req_addr);
      n_acc++;
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (adv) pc_in = pc_in + 32'd4;
    if (!rsp_hold && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic run_until(input int target, input string name);
    for (int i = 0; i < 20 && n_acc < target; i++) tick();
    check(name, 32'(n_acc), 32'(target));
  endtask

  // Scoreboard monitor: every consumed instruction must match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && instr_valid && instr_ready && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc %h data %h, expected nothing", instr_pc, instr_data);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr_data !== e.data) begin
          n_err++;
          $display("FAIL sb_instr: got pc %h data %h, expected pc %h data %h",
                   instr_pc, instr_data, e.pc, e.data);
        end
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_pc_advance", pc_advance, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_misaligned", fetch_misaligned, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_in = 32'h0;

    // Streaming
    push_exp(32'h0, 32'h1234_0013);
    push_exp(32'h4, 32'h1234_0017);
    push_exp(32'h8, 32'h1234_001B);
    run_until(3, "stream_accepts");
    imem_req_ready = 1'b0;
    check("stream_pc", pc_in, 32'hC);
    repeat (4) tick();
    check("stream_drained", instr_valid, 0);

    // Backpressure
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    push_exp(32'hC,  32'h1234_001F);
    push_exp(32'h10, 32'h1234_0003);
    repeat (6) tick();
    check("bp_accepts", 32'(n_acc), 32'd5);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_pc_advance", pc_advance, 0);
    check("bp_instr_valid", instr_valid, 1);
    check("bp_pc", pc_in, 32'h14);
    push_exp(32'h14, 32'h1234_0007);
    push_exp(32'h18, 32'h1234_000B);
    instr_ready = 1'b1;
    run_until(7, "bp_resume_accepts");
    imem_req_ready = 1'b0;
    repeat (4) tick();

    // Flush with two requests in flight
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    run_until(9, "fl2_accepts");
    flush = 1'b1;
    pc_in = 32'h100;
    tick();
    check("fl2_drain_blocks_req", imem_req_valid, 0);
    check("fl2_buf_empty", instr_valid, 0);
    rsp_hold = 1'b0;
    push_exp(32'h100, 32'h1234_0113);
    run_until(10, "fl2_redirect_accept");
    imem_req_ready = 1'b0;
    repeat (3) tick();

    // Flush coinciding with a response
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    run_until(12, "flr_accepts");
    imem_req_ready = 1'b0;
    flush          = 1'b1;
    pc_in          = 32'h200;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memf(pend.pop_front());
    tick();
    check("flr_buf_empty", instr_valid, 0);
    check("flr_drain_blocks_req", imem_req_valid, 0);
    rsp_hold       = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    push_exp(32'h200, 32'h1234_0213);
    run_until(13, "flr_redirect_accept");
    imem_req_ready = 1'b0;
    repeat (2) tick();

    // Misaligned PC
    pc_in          = 32'h6;
    imem_req_ready = 1'b1;
    #1;
    check("mis_req_blocked", imem_req_valid, 0);
    check("mis_not_yet", fetch_misaligned, 0);
    tick();
    check("mis_set", fetch_misaligned, 1);
    pc_in = 32'h8;
    #1;
    check("mis_sticky_req", imem_req_valid, 0);
    instr_ready = 1'b1;
    repeat (3) tick();
    check("mis_persist", fetch_misaligned, 1);
    flush = 1'b1;
    tick();
    check("mis_cleared", fetch_misaligned, 0);
    push_exp(32'h8, 32'h1234_001B);
    run_until(14, "mis_resume_accept");
    imem_req_ready = 1'b0;
    repeat (3) tick();

    // Asynchronous reset with one request outstanding
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    run_until(15, "ar_accept");
    imem_req_ready = 1'b0;
    check("ar_data_held", instr_data, 32'h1234_001B);
    #2;
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    #1;
    check("ar_req_valid", imem_req_valid, 0);
    check("ar_req_addr", imem_req_addr, 0);
    check("ar_pc_advance", pc_advance, 0);
    check("ar_instr_valid", instr_valid, 0);
    check("ar_instr_data", instr_data, 0);
    check("ar_instr_pc", instr_pc, 0);
    pend.delete();
    rsp_hold = 1'b0;
    tick();
    reset          = 1'b0;
    pc_in          = 32'h300;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    check("ar_stray_ignored", instr_valid, 0);
    push_exp(32'h300, 32'h1234_0313);
    imem_req_ready = 1'b1;
    run_until(16, "ar_resume_accept");
    imem_req_ready = 1'b0;
    repeat (3) tick();
    check("sb_all_consumed", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
